// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the MIPS pipeline control slice.
//   ctrl_state_t     : controller state encoding (IDLE/RUN/DRAIN/HALTED)
//   DRAIN_CYCLES_DEF : default number of bubble cycles used to drain on halt
package mips_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_HALTED = 2'd3
    } ctrl_state_t;

    localparam int DRAIN_CYCLES_DEF = 3;

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use hazard compare.
//   mem_read : ID/EX instruction is a load
//   ex_rt    : load destination register
//   id_rs    : rs field of the IF/ID instruction
//   id_rt    : rt field of the IF/ID instruction
//   uses_rt  : IF/ID instruction actually reads rt
//   hazard   : IF/ID instruction needs the load result next cycle
module hazard_detect (
    input  logic       mem_read,
    input  logic [4:0] ex_rt,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       uses_rt,
    output logic       hazard
);

    // $0 is hardwired to zero, so a load "into" it never creates a dependency.
    assign hazard = mem_read && (ex_rt != 5'd0) &&
                    ((ex_rt == id_rs) || (uses_rt && (ex_rt == id_rt)));

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Pipeline hazard controller: run/drain/halt sequencing, load-use stalls and
// taken-branch flushes for a 5-stage MIPS pipeline.
//   clk, reset_n                  : clock, async active-low reset
//   start, halt_req               : run request / drain-and-stop request
//   ID_rs, ID_rt, ID_uses_rt      : IF/ID source operands
//   EX_mem_read, EX_rt            : ID/EX load info
//   MEM_branch_taken              : branch resolved taken in MEM
//   pc_write, if_id_write         : PC and IF/ID register enables
//   if_id_flush/id_ex_flush/ex_mem_flush : bubble insertion
//   pc_src_branch                 : PC takes the branch target
//   state                         : controller state
//   stall_count, flush_count      : saturating event counters
//   cycle_count                   : cycles spent in RUN (wraps)
module pipeline_hazard_controller
    import mips_ctrl_pkg::*;
#(
    parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             halt_req,
    input  logic [4:0]       ID_rs,
    input  logic [4:0]       ID_rt,
    input  logic             ID_uses_rt,
    input  logic             EX_mem_read,
    input  logic [4:0]       EX_rt,
    input  logic             MEM_branch_taken,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             ex_mem_flush,
    output logic             pc_src_branch,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count,
    output logic [31:0]      cycle_count
);

    localparam int DW = (DRAIN_CYCLES < 1) ? 1 : $clog2(DRAIN_CYCLES + 1);

    ctrl_state_t   state_q;
    logic [DW-1:0] drain_cnt;
    logic          hazard;
    logic          branch_run;
    logic          stall_run;

    hazard_detect u_hazard (
        .mem_read (EX_mem_read),
        .ex_rt    (EX_rt),
        .id_rs    (ID_rs),
        .id_rt    (ID_rt),
        .uses_rt  (ID_uses_rt),
        .hazard   (hazard)
    );

    assign state = state_q;

    // Branch wins over a coincident load-use stall: the stalled instruction
    // is on the wrong path and gets flushed anyway.
    assign branch_run = (state_q == ST_RUN) && MEM_branch_taken;
    assign stall_run  = (state_q == ST_RUN) && hazard && !MEM_branch_taken;

    always_comb begin
        pc_write      = 1'b0;
        if_id_write   = 1'b0;
        if_id_flush   = 1'b1;
        id_ex_flush   = 1'b1;
        ex_mem_flush  = 1'b1;
        pc_src_branch = 1'b0;
        case (state_q)
            ST_RUN: begin
                pc_write     = 1'b1;
                if_id_write  = 1'b1;
                if_id_flush  = 1'b0;
                id_ex_flush  = 1'b0;
                ex_mem_flush = 1'b0;
                if (branch_run) begin
                    pc_src_branch = 1'b1;
                    if_id_flush   = 1'b1;
                    id_ex_flush   = 1'b1;
                    ex_mem_flush  = 1'b1;
                end else if (stall_run) begin
                    pc_write    = 1'b0;
                    if_id_write = 1'b0;
                    id_ex_flush = 1'b1;
                end
            end
            ST_DRAIN: begin
                // Fetch frozen, bubbles fed in while older instructions retire.
                id_ex_flush  = 1'b0;
                ex_mem_flush = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            drain_cnt   <= '0;
            stall_count <= '0;
            flush_count <= '0;
            cycle_count <= '0;
        end else begin
            case (state_q)
                ST_IDLE, ST_HALTED: begin
                    if (start && !halt_req) state_q <= ST_RUN;
                end
                ST_RUN: begin
                    cycle_count <= cycle_count + 32'd1;
                    if (branch_run && (flush_count != '1))
                        flush_count <= flush_count + CNT_W'(1);
                    if (stall_run && (stall_count != '1))
                        stall_count <= stall_count + CNT_W'(1);
                    if (halt_req) begin
                        state_q   <= ST_DRAIN;
                        drain_cnt <= DW'(DRAIN_CYCLES);
                    end
                end
                ST_DRAIN: begin
                    if (drain_cnt <= DW'(1)) state_q <= ST_HALTED;
                    else                     drain_cnt <= drain_cnt - DW'(1);
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/pipeline_hazard_controller.md
PIPELINE_HAZARD_CONTROLLER -- requirements
Module: pipeline_hazard_controller

Interface
REQ-001 SHALL have parameter DRAIN_CYCLES, default 3, meaning the number of bubble cycles inserted on halt so in-flight instructions retire.
REQ-002 SHALL have parameter CNT_W, default 16, meaning the width of the saturating stall and flush counters.
REQ-003 clk  in  1  the single clock; all state updates on posedge.
REQ-004 reset_n  in  1  reset, asynchronous, active-low.
REQ-005 start  in  1  level request to leave IDLE/HALTED and run.
REQ-006 halt_req  in  1  request to drain and stop.
REQ-007 ID_rs, ID_rt  in  5 each  source register fields of the instruction in IF/ID.
REQ-008 ID_uses_rt  in  1  the ID instruction reads rt (R-type, beq, sw).
REQ-009 EX_mem_read  in  1  the ID/EX instruction is a load (lw/lh/lhu).
REQ-010 EX_rt  in  5  load destination of the ID/EX instruction.
REQ-011 MEM_branch_taken  in  1  MEM_branch AND MEM_zero.
REQ-012 pc_write, if_id_write  out  1 each  enable the PC and IF/ID registers.
REQ-013 if_id_flush, id_ex_flush, ex_mem_flush  out  1 each  load a bubble (all-zero) into that pipeline register.
REQ-014 pc_src_branch  out  1  PC loads IF_branch_address instead of PC+4.
REQ-015 state  out  2  IDLE=0, RUN=1, DRAIN=2, HALTED=3.
REQ-016 stall_count, flush_count  out  CNT_W each  saturating event counters.
REQ-017 cycle_count  out  32  cycles spent in RUN, wrapping modulo 2^32.

Function
REQ-018 Control outputs SHALL be combinational from state and current inputs (same-cycle response); state and counters SHALL be registered.
REQ-019 IDLE: pc_write=0, if_id_write=0, all three flushes=1; start=1 -> RUN next cycle.
REQ-020 RUN, default: pc_write=1, if_id_write=1, flushes=0, pc_src_branch=0.
REQ-021 Load-use hazard = EX_mem_read AND EX_rt!=0 AND (EX_rt==ID_rs OR (ID_uses_rt AND EX_rt==ID_rt)); in RUN it SHALL give pc_write=0, if_id_write=0, id_ex_flush=1 for that cycle and increment stall_count.
REQ-022 MEM_branch_taken in RUN SHALL give pc_src_branch=1, pc_write=1, and if_id_flush, id_ex_flush, ex_mem_flush all 1 for that cycle, and SHALL increment flush_count.
REQ-023 Branch SHALL take priority over load-use hazard in the same cycle; only flush_count increments.
REQ-024 halt_req in RUN -> DRAIN; the counter loads DRAIN_CYCLES; a branch or hazard in that same cycle SHALL still be serviced.
REQ-025 DRAIN: pc_write=0, if_id_write=0, if_id_flush=1; the counter decrements each cycle; at 1 -> HALTED.
REQ-026 In DRAIN, MEM_branch_taken SHALL be ignored (no redirect, no flush_count increment).
REQ-027 HALTED: outputs as IDLE; start=1 AND halt_req=0 -> RUN.
REQ-028 halt_req and start both high in IDLE/HALTED: remain in the current state.
REQ-029 stall_count and flush_count SHALL saturate at 2^CNT_W-1; cycle_count SHALL increment only in RUN.

Reset
REQ-030 reset_n low SHALL immediately force state=IDLE and all counters to 0, giving pc_write=0, if_id_write=0, flushes=1, pc_src_branch=0.
REQ-031 Reset asserted mid-DRAIN or mid-stall SHALL abandon the operation with no residual effect after release.

Structure
REQ-032 State encodings and DRAIN_CYCLES default SHALL live in shared package mips_ctrl_pkg.
REQ-033 A single sub-module hazard_detect (combinational load-use compare) is natural; everything else is flat.

Verification
REQ-034 Reset, start=1 -> state 0 then 1 next cycle; pc_write=1; all counters 0.
REQ-035 lw $t7,0($0) then add $s0,$t7,$t1 (EX_rt=15, ID_rs=15) -> exactly one stall cycle: pc_write=0, id_ex_flush=1, stall_count=1.
REQ-036 EX_rt=0 with ID_rs=0, EX_mem_read=1 -> no stall.
REQ-037 MEM_branch_taken=1 with a load-use hazard in the same cycle -> pc_src_branch=1, all three flushes=1, flush_count=1, stall_count unchanged.
REQ-038 halt_req in RUN -> DRAIN for 3 cycles, then HALTED; cycle_count frozen; start -> RUN.
REQ-039 Drive 70000 stall events -> stall_count holds 65535.
